// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: shared FSM state type and one-hot encoder for the round-robin scheduler
package rr_sched_pkg;
  localparam int MAX_PORTS = 32;
  typedef enum logic {S_IDLE, S_GRANT} state_e;
  function automatic logic [4:0] oh2idx(input logic [MAX_PORTS-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) idx |= oh[i] ? 5'(i) : 5'd0;
    return idx;
  endfunction
endpackage

// File: rtl/rr_grant_scheduler_arb.sv
// rr_grant_scheduler_arb: fixed-priority arbiter, lowest requesting index wins
module rr_grant_scheduler_arb #(
  parameter int NUM_PORTS = 17
) (
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);
  assign gnt_o = req_i & (~req_i + NUM_PORTS'(1));
endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin arbiter with registered one-hot grant and bounded hold time
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int NUM_PORTS = 17,
  parameter int MAX_HOLD  = 8,
  localparam int ID_W     = $clog2(NUM_PORTS),
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic [HOLD_W-1:0]    hold_cnt_o
);
  state_e                r_state, w_state_nx;
  logic [NUM_PORTS-1:0]  r_gnt, w_gnt_nx, w_cand, w_mask, w_gnt_m, w_gnt_u, w_sel;
  logic [ID_W-1:0]       r_ptr, w_ptr_nx, w_sel_id, w_ptr_inc;
  logic [HOLD_W-1:0]     r_hold, w_hold_nx;
  logic                  w_keep, w_new, w_hold_max;

  // The current owner is never a candidate, so a rotation cannot re-pick it.
  assign w_cand = req_i & ~r_gnt;
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) w_mask[i] = i >= int'(r_ptr);
  end
  rr_grant_scheduler_arb #(.NUM_PORTS(NUM_PORTS)) u_arb_m (.req_i(w_cand & w_mask), .gnt_o(w_gnt_m));
  rr_grant_scheduler_arb #(.NUM_PORTS(NUM_PORTS)) u_arb_u (.req_i(w_cand), .gnt_o(w_gnt_u));
  assign w_sel     = |w_gnt_m ? w_gnt_m : w_gnt_u;
  assign w_sel_id  = ID_W'(oh2idx(MAX_PORTS'(w_sel)));
  assign w_ptr_inc = w_sel_id == ID_W'(NUM_PORTS - 1) ? '0 : w_sel_id + ID_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_ptr   <= w_ptr_nx;
      r_hold  <= w_hold_nx;
    end
  end

  always_comb begin
    w_hold_max = r_hold == HOLD_W'(MAX_HOLD - 1);
    w_keep     = r_state == S_GRANT && |(req_i & r_gnt) && (!w_hold_max || ~|w_cand);
    w_new      = !w_keep && |w_cand;
    w_state_nx = (w_keep || w_new) ? S_GRANT : S_IDLE;
    w_gnt_nx   = w_keep ? r_gnt : w_new ? w_sel : '0;
    w_hold_nx  = !w_keep ? '0 : w_hold_max ? r_hold : r_hold + HOLD_W'(1);
    w_ptr_nx   = w_new ? w_ptr_inc : r_ptr;
  end

  always_comb begin
    gnt_o       = r_gnt;
    gnt_valid_o = |r_gnt;
    gnt_id_o    = ID_W'(oh2idx(MAX_PORTS'(r_gnt)));
    hold_cnt_o  = r_hold;
  end
endmodule
